// File: rtl/serializer_block.sv
// rtl/serializer_block.sv - parallel-to-serial stage emitting an N-word bundle one word per handshake
//
// Purpose:
//   Accepts one N_SAMPLES-word bundle per recv handshake, holds it in an
//   internal register and emits it on the send side one word per handshake,
//   word 0 (LSBs of recv_msg) first. Outputs are combinational from the
//   state, word counter and bundle register.
//
// Configuration macro:
//   SERIALIZER_BACK_TO_BACK_EN - when defined, a new bundle may be accepted
//   in the same cycle the last word of the current bundle is handed off, so
//   bundles stream with no idle cycle between them. When undefined, the
//   block returns to IDLE for one cycle between bundles.
//
// Ports:
//   clk       in   clock, all state updates on the rising edge
//   reset     in   synchronous active-high reset
//   recv_msg  in   parallel bundle, word i = recv_msg[i*BIT_WIDTH +: BIT_WIDTH]
//   recv_val  in   upstream bundle valid
//   recv_rdy  out  block can accept a bundle
//   send_msg  out  current serial word
//   send_val  out  send_msg valid
//   send_rdy  in   downstream accepts the word

module serializer_block #(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [BIT_WIDTH*N_SAMPLES-1:0] recv_msg,
  input  logic                           recv_val,
  output logic                           recv_rdy,
  output logic [BIT_WIDTH-1:0]           send_msg,
  output logic                           send_val,
  input  logic                           send_rdy
);

  localparam int CW = $clog2(N_SAMPLES);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [BIT_WIDTH-1:0] bundle_q [N_SAMPLES];

  logic last_word;
  logic load_bundle;
  logic recv_fire;
  logic send_fire;

  assign last_word = (count_q == CW'(N_SAMPLES - 1));

  // Output decode; everything is forced low while reset is held so the
  // neighbours never see a handshake against stale pre-reset state.
  always_comb begin
    recv_rdy = 1'b0;
    send_val = 1'b0;
    send_msg = '0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: recv_rdy = 1'b1;
        ST_SEND: begin
          send_val = 1'b1;
          send_msg = bundle_q[count_q];
`ifdef SERIALIZER_BACK_TO_BACK_EN
          // Only open the input when the final word is leaving this cycle,
          // which makes recv_rdy combinationally follow send_rdy.
          recv_rdy = send_rdy && last_word;
`endif
        end
        default: ;
      endcase
    end
  end

  assign recv_fire = recv_val && recv_rdy;
  assign send_fire = send_val && send_rdy;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    load_bundle = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (recv_fire) begin
          load_bundle = 1'b1;
          count_d     = '0;
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (send_fire) begin
          if (last_word) begin
            count_d = '0;
            state_d = ST_IDLE;
            // A bundle arriving alongside the last word keeps us in SEND.
            if (recv_fire) begin
              load_bundle = 1'b1;
              state_d     = ST_SEND;
            end
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      for (int i = 0; i < N_SAMPLES; i++) begin
        bundle_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (load_bundle) begin
        for (int i = 0; i < N_SAMPLES; i++) begin
          bundle_q[i] <= recv_msg[i*BIT_WIDTH +: BIT_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_serializer_block.sv
// tb/tb_serializer_block.sv - self-checking bench for serializer_block

module tb_serializer_block;

  localparam int W = 32;
  localparam int N = 8;

`ifdef SERIALIZER_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic           clk;
  logic           reset;
  logic [W*N-1:0] recv_msg;
  logic           recv_val;
  logic           recv_rdy;
  logic [W-1:0]   send_msg;
  logic           send_val;
  logic           send_rdy;

  int checks;
  int errors;

  serializer_block #(.BIT_WIDTH(W), .N_SAMPLES(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .recv_msg (recv_msg),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .send_msg (send_msg),
    .send_val (send_val),
    .send_rdy (send_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W*N-1:0] seq_bundle(input logic [W-1:0] base);
    logic [W*N-1:0] b;
    for (int i = 0; i < N; i++) b[i*W +: W] = base + W'(i);
    return b;
  endfunction

  function automatic logic [W*N-1:0] rand_bundle();
    logic [W*N-1:0] b;
    for (int i = 0; i < N; i++) b[i*W +: W] = W'($urandom);
    return b;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Present a bundle for one cycle in IDLE and confirm it is taken.
  task automatic load(input logic [W*N-1:0] b, input string name);
    recv_msg = b;
    recv_val = 1'b1;
    @(negedge clk);
    checks++;
    if (recv_rdy !== 1'b1) begin
      errors++;
      $display("FAIL %s_load_rdy: recv_rdy=%b expected 1", name, recv_rdy);
    end
    next_cycle();
    recv_val = 1'b0;
    recv_msg = rand_bundle();
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    recv_val = 1'b1;
    recv_msg = rand_bundle();
    send_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (recv_rdy !== 1'b0 || send_val !== 1'b0 || send_msg !== '0) begin
        errors++;
        $display("FAIL reset_hold: rdy=%b val=%b msg=%h expected 0/0/0", recv_rdy, send_val, send_msg);
      end
      next_cycle();
    end
    reset    = 1'b0;
    recv_val = 1'b0;
    @(negedge clk);
    checks++;
    if (recv_rdy !== 1'b1 || send_val !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rdy=%b val=%b expected 1/0", recv_rdy, send_val);
    end
    next_cycle();
  endtask

  task automatic test_single_bundle();
    send_rdy = 1'b1;
    load(seq_bundle(32'h10), "single");
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      checks++;
      if (send_val !== 1'b1 || send_msg !== W'(32'h10 + i)) begin
        errors++;
        $display("FAIL single_word%0d: val=%b msg=%h expected 1/%h", i, send_val, send_msg, W'(32'h10 + i));
      end
      checks++;
      if (recv_rdy !== (B2B && i == N - 1)) begin
        errors++;
        $display("FAIL single_rdy%0d: recv_rdy=%b expected %b", i, recv_rdy, (B2B && i == N - 1));
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (recv_rdy !== 1'b1 || send_val !== 1'b0) begin
      errors++;
      $display("FAIL single_after: rdy=%b val=%b expected 1/0", recv_rdy, send_val);
    end
    next_cycle();
  endtask

  task automatic test_backpressure();
    bit pattern [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int delivered = 0;
    int cyc = 0;
    send_rdy = 1'b1;
    load(seq_bundle(32'h10), "bp");
    while (delivered < N && cyc < 200) begin
      send_rdy = pattern[cyc % 4];
      @(negedge clk);
      checks++;
      if (send_val !== 1'b1 || send_msg !== W'(32'h10 + delivered)) begin
        errors++;
        $display("FAIL bp_word%0d_cyc%0d: val=%b msg=%h expected 1/%h", delivered, cyc, send_val, send_msg, W'(32'h10 + delivered));
      end
      if (send_val && send_rdy) delivered++;
      next_cycle();
      cyc++;
    end
    checks++;
    if (delivered != N) begin
      errors++;
      $display("FAIL bp_timeout: delivered=%0d expected %0d", delivered, N);
    end
    send_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (send_val !== 1'b0) begin
      errors++;
      $display("FAIL bp_extra: send_val=%b expected 0", send_val);
    end
    next_cycle();
  endtask

  task automatic test_upstream_corruption();
    send_rdy = 1'b1;
    load(seq_bundle(32'h10), "corrupt");
    for (int i = 0; i < N; i++) begin
      recv_msg = '1;
      recv_val = (i < N - 1);
      @(negedge clk);
      checks++;
      if (recv_rdy !== (B2B && i == N - 1)) begin
        errors++;
        $display("FAIL corrupt_rdy%0d: recv_rdy=%b expected %b", i, recv_rdy, (B2B && i == N - 1));
      end
      checks++;
      if (send_msg !== W'(32'h10 + i)) begin
        errors++;
        $display("FAIL corrupt_word%0d: msg=%h expected %h", i, send_msg, W'(32'h10 + i));
      end
      next_cycle();
    end
    recv_val = 1'b0;
    @(negedge clk);
    checks++;
    if (send_val !== 1'b0) begin
      errors++;
      $display("FAIL corrupt_after: send_val=%b expected 0", send_val);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_bundle();
    send_rdy = 1'b1;
    load(seq_bundle(32'h10), "midrst");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (send_msg !== W'(32'h10 + i)) begin
        errors++;
        $display("FAIL midrst_pre%0d: msg=%h expected %h", i, send_msg, W'(32'h10 + i));
      end
      next_cycle();
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (send_val !== 1'b0 || recv_rdy !== 1'b0 || send_msg !== '0) begin
      errors++;
      $display("FAIL midrst_during: val=%b rdy=%b msg=%h expected 0/0/0", send_val, recv_rdy, send_msg);
    end
    next_cycle();
    reset    = 1'b0;
    recv_msg = seq_bundle(32'h20);
    recv_val = 1'b1;
    @(negedge clk);
    checks++;
    if (send_val !== 1'b0 || recv_rdy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_after: val=%b rdy=%b expected 0/1", send_val, recv_rdy);
    end
    next_cycle();
    recv_val = 1'b0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      checks++;
      if (send_val !== 1'b1 || send_msg !== W'(32'h20 + i)) begin
        errors++;
        $display("FAIL midrst_word%0d: val=%b msg=%h expected 1/%h", i, send_val, send_msg, W'(32'h20 + i));
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] got [$];
    int           got_cyc [$];
    int accepted = 0;
    int cyc = 0;
    send_rdy = 1'b1;
    recv_msg = seq_bundle(32'h10);
    recv_val = 1'b1;
    while (got.size() < 2 * N && cyc < 100) begin
      @(negedge clk);
      if (recv_val && recv_rdy) accepted++;
      if (send_val && send_rdy) begin
        got.push_back(send_msg);
        got_cyc.push_back(cyc);
      end
      next_cycle();
      cyc++;
      if (accepted == 1) recv_msg = seq_bundle(32'h20);
      if (accepted >= 2) recv_val = 1'b0;
    end
    recv_val = 1'b0;
    checks++;
    if (got.size() != 2 * N) begin
      errors++;
      $display("FAIL b2b_count: words=%0d expected %0d", got.size(), 2 * N);
    end else begin
      for (int i = 0; i < 2 * N; i++) begin
        logic [W-1:0] exp_w;
        exp_w = (i < N) ? W'(32'h10 + i) : W'(32'h20 + i - N);
        checks++;
        if (got[i] !== exp_w) begin
          errors++;
          $display("FAIL b2b_word%0d: msg=%h expected %h", i, got[i], exp_w);
        end
      end
      checks++;
      if (got_cyc[N] - got_cyc[N-1] != (B2B ? 1 : 2)) begin
        errors++;
        $display("FAIL b2b_gap: spacing=%0d expected %0d", got_cyc[N] - got_cyc[N-1], (B2B ? 1 : 2));
      end
      checks++;
      if (got_cyc[2*N-1] - got_cyc[0] + 1 != (B2B ? 2 * N : 2 * N + 1)) begin
        errors++;
        $display("FAIL b2b_span: cycles=%0d expected %0d", got_cyc[2*N-1] - got_cyc[0] + 1, (B2B ? 2 * N : 2 * N + 1));
      end
    end
    repeat (2) next_cycle();
  endtask

  // Model: the block owes every accepted-but-undelivered word, in order.
  // It can take a new bundle only when it owes nothing (or, with back-to-back
  // enabled, when the single remaining word is leaving this cycle).
  task automatic test_random_stream();
    logic [W-1:0] owed [$];
    int sent_bundles = 0;
    int cyc = 0;
    bit exp_rdy;
    while ((sent_bundles < 20 || owed.size() > 0) && cyc < 3000) begin
      send_rdy = ($urandom_range(0, 99) < 60);
      recv_val = (sent_bundles < 20) && ($urandom_range(0, 99) < 70);
      recv_msg = rand_bundle();
      @(negedge clk);
      exp_rdy = (owed.size() == 0) || (B2B && owed.size() == 1 && send_rdy);
      checks++;
      if (recv_rdy !== exp_rdy) begin
        errors++;
        $display("FAIL rand_rdy_cyc%0d: recv_rdy=%b expected %b", cyc, recv_rdy, exp_rdy);
      end
      checks++;
      if (send_val !== (owed.size() > 0)) begin
        errors++;
        $display("FAIL rand_val_cyc%0d: send_val=%b expected %b", cyc, send_val, (owed.size() > 0));
      end
      if (owed.size() > 0) begin
        checks++;
        if (send_msg !== owed[0]) begin
          errors++;
          $display("FAIL rand_msg_cyc%0d: msg=%h expected %h", cyc, send_msg, owed[0]);
        end
        if (send_rdy) void'(owed.pop_front());
      end
      if (recv_val && exp_rdy) begin
        for (int i = 0; i < N; i++) owed.push_back(recv_msg[i*W +: W]);
        sent_bundles++;
      end
      next_cycle();
      cyc++;
    end
    recv_val = 1'b0;
    checks++;
    if (sent_bundles != 20 || owed.size() != 0) begin
      errors++;
      $display("FAIL rand_timeout: bundles=%0d owed=%0d expected 20/0", sent_bundles, owed.size());
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    recv_val = 1'b0;
    recv_msg = '0;
    send_rdy = 1'b0;
    #1;
    test_reset();
    test_single_bundle();
    test_backpressure();
    test_upstream_corruption();
    test_reset_mid_bundle();
    test_back_to_back();
    test_random_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
